fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch front end of the RISC-V pipeline. It consumes the branch-resolution outputs `pc_sel` and `branch_pc` and owns the architectural PC register. It drives the instruction-memory address and loads the IF/ID pipeline register, handling sequential fetch, redirect flush, hazard stall and halt.

Parameters:
WIDTH, 9, PC / instruction-memory byte-address width (matches branch-resolution PC width)
RESET_PC, 0, PC value loaded on reset (WIDTH bits, word aligned)
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/halt

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
stall_i  input  1  hazard-unit hold request (load-use); freezes PC and IF/ID
pc_sel_i  input  1  redirect request from branch resolution (1 = take branch_pc_i)
branch_pc_i  input  32  redirect target from branch resolution
imem_addr_o  output  WIDTH  instruction-memory address, equal to current PC (combinational from PC register)
imem_rdata_i  input  32  instruction word at imem_addr_o, valid same cycle (asynchronous-read ROM)
if_pc_o  output  WIDTH  IF/ID register: PC of fetched instruction
if_instr_o  output  32  IF/ID register: fetched instruction
if_valid_o  output  1  IF/ID register: 1 = real instruction, 0 = bubble
halted_o  output  1  core halted (sticky until reset)
misalign_o  output  1  sticky: a redirect target had branch_pc_i[1:0] != 0
redirect_cnt_o  output  16  saturating count of taken redirects (halt excluded)

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; if_pc_o=0; if_instr_o=NOP_INSTR; if_valid_o=0.
  - halted_o=0; misalign_o=0; redirect_cnt_o=0; FSM=RUN.
  - Reset overrides every other input, including in HALTED and during stall or redirect.
- FSM states: RUN, HALTED. No other states.
- Halt detect: pc_sel_i=1 and full 32-bit branch_pc_i==32'hFFFFFFFF.
- RUN, per posedge, priority highest first:
  1. Halt detect:
     - FSM->HALTED; halted_o<=1; pc unchanged.
     - IF/ID <= {pc, NOP_INSTR, valid=0}.
     - redirect_cnt_o unchanged.
  2. Redirect (pc_sel_i=1, not halt):
     - pc <= {branch_pc_i[WIDTH-1:2], 2'b00}; upper bits truncated.
     - IF/ID <= {pc, NOP_INSTR, valid=0} (flush wrong-path instruction).
     - redirect_cnt_o += 1, saturating at 16'hFFFF.
     - If branch_pc_i[1:0]!=0, misalign_o<=1.
     - Redirect wins over a simultaneous stall_i=1.
  3. Stall (stall_i=1): pc and IF/ID hold all values.
  4. Normal:
     - pc <= pc + 4, wrapping modulo 2^WIDTH (e.g. 9'h1FC -> 9'h000).
     - IF/ID <= {pc, imem_rdata_i, valid=1}.
- HALTED:
  - pc, IF/ID (valid=0, NOP), and counters frozen.
  - pc_sel_i, stall_i and branch_pc_i are ignored.
  - Exit only via reset.
- Latency:
  - A redirect asserted in cycle N makes imem_addr_o equal the target in cycle N+1.
  - The first valid target instruction appears in IF/ID at the N+2 edge.
  - Exactly one bubble per redirect.
- pc_sel_i=0 with any branch_pc_i value (including all ones) is a normal fetch; branch_pc_i is don't-care.
- misalign_o is sticky; it clears only on reset.
- Outputs are registered except imem_addr_o.

Test Plan:
- Reset then 4 free-running cycles, ROM word[k]=k+1, RESET_PC=0 -> IF/ID valid sequence (pc,instr) = (0,1),(4,2),(8,3); halted_o=0.
- In RUN at pc=0x010, pulse pc_sel_i=1, branch_pc_i=0x40 -> next imem_addr_o=0x040; one IF/ID bubble (valid=0, instr=0x13); next valid = (0x040, word 0x040); redirect_cnt_o=1.
- stall_i=1 for 3 cycles at pc=0x020, then pc_sel_i=1 with target 0x100 while stall_i=1 -> PC/IF/ID hold during stall; redirect taken despite stall; pc=0x100.
- pc_sel_i=1, branch_pc_i=32'hFFFFFFFF -> halted_o=1, if_valid_o=0, pc frozen; later pc_sel_i=1/0x80 ignored; rst_n=0 one cycle -> pc=RESET_PC, halted_o=0.
- Free-run to pc=0x1FC with WIDTH=9 -> next pc=0x000. Redirect to 0x00000206 -> pc=0x004, misalign_o=1 and held sticky.
- Force redirect_cnt_o to 16'hFFFE via 65534 redirects (or a bench-backdoor preload), then 3 more redirects -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory address
// and loads the IF/ID register (sequential fetch, redirect flush, stall, halt).
module fetch_pc_unit #(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             pc_sel_i,
  input  logic [31:0]      branch_pc_i,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [31:0]      if_instr_o,
  output logic             if_valid_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [15:0]      redirect_cnt_o
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] if_pc_q,    if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic             if_valid_q, if_valid_d;
  logic             misalign_q, misalign_d;
  logic [15:0]      cnt_q,      cnt_d;
  logic             halt_req;

  // The all-ones target is reserved as the halt request, never a real redirect.
  assign halt_req = pc_sel_i && (branch_pc_i == 32'hFFFF_FFFF);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (state_q == S_RUN) begin
      if (halt_req) begin
        state_d    = S_HALTED;
        if_pc_d    = pc_q;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end else if (pc_sel_i) begin
        pc_d       = {branch_pc_i[WIDTH-1:2], 2'b00};
        if_pc_d    = pc_q;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (branch_pc_i[1:0] != 2'b00) begin
          misalign_d = 1'b1;
        end
      end else if (!stall_i) begin
        pc_d       = pc_q + WIDTH'(4);
        if_pc_d    = pc_q;
        if_instr_d = imem_rdata_i;
        if_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign if_pc_o        = if_pc_q;
  assign if_instr_o     = if_instr_q;
  assign if_valid_o     = if_valid_q;
  assign halted_o       = (state_q == S_HALTED);
  assign misalign_o     = misalign_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a reference model queues the expected post-edge view of
// every output for each driven cycle; test tasks pop and compare it after the edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        pc_sel_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic [8:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [8:0]  if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [15:0] redirect_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0]  ifpc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [15:0] cnt;
    logic [8:0]  addr;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, exp;

  // Reference model state
  int unsigned m_pc, m_ifpc, m_instr, m_cnt;
  bit          m_valid, m_halt, m_mis;

  fetch_pc_unit #(.WIDTH(9), .RESET_PC(9'h000), .NOP_INSTR(32'h00000013)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .pc_sel_i      (pc_sel_i),
    .branch_pc_i   (branch_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_valid_o    (if_valid_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  // Asynchronous ROM: word k holds k+1
  function automatic logic [31:0] rom(input logic [8:0] a);
    return 32'(a >> 2) + 32'd1;
  endfunction
  assign imem_rdata_i = rom(imem_addr_o);

  function automatic obs_t sample();
    obs_t o;
    o.ifpc = if_pc_o; o.instr = if_instr_o; o.valid = if_valid_o;
    o.halted = halted_o; o.mis = misalign_o; o.cnt = redirect_cnt_o; o.addr = imem_addr_o;
    return o;
  endfunction

  // Drive one cycle, advance the model, queue the expectation, then wait past the edge.
  task automatic cycle(input bit rst, input bit stl, input bit sel, input logic [31:0] bpc);
    obs_t e;
    rst_n = ~rst; stall_i = stl; pc_sel_i = sel; branch_pc_i = bpc;
    if (rst) begin
      m_pc = 0; m_ifpc = 0; m_instr = 32'h13; m_valid = 0; m_halt = 0; m_mis = 0; m_cnt = 0;
    end else if (m_halt) begin
      // frozen
    end else if (sel && bpc == 32'hFFFFFFFF) begin
      m_halt = 1; m_ifpc = m_pc; m_instr = 32'h13; m_valid = 0;
    end else if (sel) begin
      m_ifpc = m_pc; m_instr = 32'h13; m_valid = 0;
      m_pc = bpc & 32'h1FC;
      if (m_cnt < 65535) m_cnt++;
      if (bpc[1:0] != 0) m_mis = 1;
    end else if (!stl) begin
      m_ifpc = m_pc; m_instr = (m_pc / 4) + 1; m_valid = 1;
      m_pc = (m_pc + 4) % 512;
    end
    e.ifpc = m_ifpc[8:0]; e.instr = m_instr; e.valid = m_valid; e.halted = m_halt;
    e.mis = m_mis; e.cnt = m_cnt[15:0]; e.addr = m_pc[8:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      got = sample(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL seq_fetch[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++;
    if (if_pc_o !== 9'h00C || if_instr_o !== 32'd4 || if_valid_o !== 1'b1 || halted_o !== 1'b0) begin
      errors++; $display("FAIL seq_fetch_last got pc=%h instr=%h v=%b h=%b exp pc=00c instr=4 v=1 h=0",
                         if_pc_o, if_instr_o, if_valid_o, halted_o);
    end
  endtask

  task automatic test_redirect();
    cycle(1, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 0); void'(exp_q.pop_front()); end
    cycle(0, 0, 1, 32'h40);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL redirect_bubble got=%h exp=%h", got, exp); end
    checks++;
    if (imem_addr_o !== 9'h040 || if_valid_o !== 1'b0 || if_instr_o !== 32'h13 || if_pc_o !== 9'h010) begin
      errors++; $display("FAIL redirect_addr got addr=%h v=%b instr=%h pc=%h exp addr=040 v=0 instr=13 pc=010",
                         imem_addr_o, if_valid_o, if_instr_o, if_pc_o);
    end
    cycle(0, 0, 0, 0);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL redirect_target got=%h exp=%h", got, exp); end
    checks++;
    if (if_pc_o !== 9'h040 || if_instr_o !== 32'd17 || if_valid_o !== 1'b1 || redirect_cnt_o !== 16'd1) begin
      errors++; $display("FAIL redirect_first_valid got pc=%h instr=%h v=%b cnt=%0d exp pc=040 instr=11 v=1 cnt=1",
                         if_pc_o, if_instr_o, if_valid_o, redirect_cnt_o);
    end
  endtask

  task automatic test_stall();
    cycle(1, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin cycle(0, 0, 0, 0); void'(exp_q.pop_front()); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 32'hFFFFFFFF);
      got = sample(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++;
    if (imem_addr_o !== 9'h020 || if_pc_o !== 9'h01C) begin
      errors++; $display("FAIL stall_pc got addr=%h ifpc=%h exp addr=020 ifpc=01c", imem_addr_o, if_pc_o);
    end
    cycle(0, 1, 1, 32'h100);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL stall_redirect got=%h exp=%h", got, exp); end
    checks++;
    if (imem_addr_o !== 9'h100 || redirect_cnt_o !== 16'd1) begin
      errors++; $display("FAIL stall_redirect_pc got addr=%h cnt=%0d exp addr=100 cnt=1", imem_addr_o, redirect_cnt_o);
    end
  endtask

  task automatic test_halt();
    cycle(0, 0, 1, 32'hFFFFFFFF);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_enter got=%h exp=%h", got, exp); end
    checks++;
    if (halted_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== 9'h100) begin
      errors++; $display("FAIL halt_state got h=%b v=%b addr=%h exp h=1 v=0 addr=100", halted_o, if_valid_o, imem_addr_o);
    end
    cycle(0, 0, 1, 32'h80);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      got = sample(); exp = exp_q.pop_front();
      if (i == 2) begin
        checks++;
        if (got !== exp) begin errors++; $display("FAIL halt_frozen got=%h exp=%h", got, exp); end
      end
    end
    cycle(1, 1, 1, 32'hFFFFFFFF);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_reset got=%h exp=%h", got, exp); end
    checks++;
    if (halted_o !== 1'b0 || imem_addr_o !== 9'h000) begin
      errors++; $display("FAIL halt_reset_pc got h=%b addr=%h exp h=0 addr=000", halted_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap_misalign();
    cycle(0, 0, 1, 32'h1F0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 32'hFFFFFFFF);
      got = sample(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap_run[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++;
    if (imem_addr_o !== 9'h000) begin errors++; $display("FAIL wrap_pc got=%h exp=000", imem_addr_o); end
    cycle(0, 0, 1, 32'h00000206);
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL misalign_redirect got=%h exp=%h", got, exp); end
    checks++;
    if (imem_addr_o !== 9'h004 || misalign_o !== 1'b1) begin
      errors++; $display("FAIL misalign_set got addr=%h mis=%b exp addr=004 mis=1", imem_addr_o, misalign_o);
    end
    for (int i = 0; i < 3; i++) begin cycle(0, 0, (i == 1), 32'h20); void'(exp_q.pop_front()); end
    checks++;
    if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_sticky got=%b exp=1", misalign_o); end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 65534; i++) begin cycle(0, 0, 1, 32'h40); void'(exp_q.pop_front()); end
    checks++;
    if (redirect_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", redirect_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, i[0], 1, 32'h80);
      got = sample(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL sat_step[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++;
    if (redirect_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h exp=ffff", redirect_cnt_o); end
  endtask

  initial begin
    #2;
    test_reset();
    test_redirect();
    test_stall();
    test_halt();
    test_wrap_misalign();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
